gb_wr_sampler: RTL and testbench
================================

// Module: gb_wr_sampler
// PURPOSE
//  Samples the asynchronous Game Boy cartridge bus with the cart-local clock and turns each
//  valid CPU write cycle into one clean single-cycle strobe carrying A[15:12] and D[7:0].
//  Sits directly upstream of the MBC bank-register file, which consumes wr_stb/wr_addr/wr_data
//  instead of clocking its registers on combinational write decodes.
// PARAMETERS
//  SYNC_STAGES  2    flops per synchronizer chain (>=2); wr, a, d share the same depth
//  MIN_LOW      2    synced WR-low cycles required before a write is accepted (>=1)
//  MAX_LOW      64   WR-low cycles after which the cycle is declared stuck (> MIN_LOW)
//  CNT_W        7    low-counter width; must hold MAX_LOW
// PORTS
//  clk        in   1  cart-local clock, all state on rising edge
//  rst        in   1  synchronous reset, active-high
//  gb_wr_n    in   1  raw GB_WR, asynchronous
//  gb_a       in   4  raw GB_A[15:12], asynchronous
//  gb_d       in   8  raw GB_D[7:0], asynchronous
//  wr_stb     out  1  one-cycle pulse: a write completed
//  wr_addr    out  4  A[15:12] of the write, valid while wr_stb=1, held after
//  wr_data    out  8  D[7:0] of the write, valid while wr_stb=1, held after
//  busy       out  1  1 while a write cycle is in progress (state != IDLE)
//  abort_cnt  out  8  saturating count of rejected write cycles
// BEHAVIOUR
//  - One clock; reset is synchronous and active-high. On rst: state=IDLE, wr_stb=0, wr_addr=0,
//    wr_data=0, abort_cnt=0, low_cnt=0, sync chains to wr=1/a=0/d=0; busy=0.
//  - wr, a, d each pass through SYNC_STAGES flops; wr_s, a_s, d_s are mutually aligned.
//  - FSM states IDLE, LOW, STUCK, COMMIT:
//    IDLE  : wr_s=0 -> LOW, low_cnt=1, lat_a<=a_s, lat_d<=d_s.
//    LOW   : wr_s=0 -> low_cnt++, lat_d<=d_s each cycle (last low sample wins);
//            a_s != lat_a -> STUCK, abort_cnt++ (address moved mid-write);
//            low_cnt reaches MAX_LOW -> STUCK, abort_cnt++;
//            wr_s=1 and low_cnt>=MIN_LOW -> COMMIT; wr_s=1 and low_cnt<MIN_LOW -> IDLE, abort_cnt++.
//    STUCK : stay until wr_s=1, then IDLE; never emits wr_stb.
//    COMMIT: wr_stb=1, wr_addr<=lat_a, wr_data<=lat_d for exactly this cycle; -> IDLE
//            (if wr_s=0 already, go straight to LOW with fresh latch, no idle cycle lost).
//  - Latency: wr_stb is high SYNC_STAGES+1 clk after the first clk edge sampling raw WR high.
//  - abort_cnt saturates at 8'hFF; never wraps.
//  - wr_stb is never asserted two cycles in a row.
//  - rst asserted mid-cycle (LOW/COMMIT): no strobe emitted, FSM in IDLE next cycle; if raw WR
//    is still low after rst release the remainder is treated as a new cycle (may abort as short).
//  - Reads (gb_wr_n stays 1) never change any output.
// CONFIGURATION
//  NCGB_WR_DATA_VOTE_EN: defined -> lat_d in LOW updates only when d_s equals the previous
//  cycle's d_s (two-sample agreement), filtering bus settling glitches; if d_s never settles
//  the last agreed value (or IDLE-entry sample) is used. Undefined -> lat_d<=d_s every LOW cycle.
// STRUCTURE
//  - Package ncgb_pkg: FSM state enum; address nibble constants ADDR_RAM_EN_0=4'h0,
//    ADDR_RAM_EN_1=4'h1, ADDR_ROM_LO=4'h2, ADDR_ROM_HI=4'h3, ADDR_RAM_BANK_0=4'h4,
//    ADDR_RAM_BANK_1=4'h5, ADDR_GAME_EN=4'hA, ADDR_GAME_SEL=4'hB (shared with the consumer).
//  - One sub-module: ncgb_sync (parameterised width/depth flop chain, reset value input),
//    instantiated three times (wr, a, d).
// TESTING
//  1 Raw write A=4'h2 D=8'h05, WR low 10 clk -> one wr_stb, wr_addr=4'h2, wr_data=8'h05,
//    at SYNC_STAGES+1 clk after WR rise; abort_cnt=0.
//  2 WR low 1 clk (MIN_LOW=2), A=4'h4 D=8'h13 -> no wr_stb; abort_cnt=1; busy back to 0.
//  3 WR held low 100 clk -> STUCK at low_cnt=64, abort_cnt=1, no wr_stb after WR rise.
//  4 A changes 4'h2->4'h3 while WR low -> no strobe, abort_cnt=1; following clean write
//    A=4'h3 D=8'h01 -> wr_stb with 4'h3/8'h01.
//  5 D changes 8'hAA->8'h0A on last low cycle -> wr_data=8'h0A; with NCGB_WR_DATA_VOTE_EN and a
//    single-cycle 8'hFF glitch mid-low then 8'h0A held 3 cycles -> wr_data=8'h0A.
//  6 rst pulsed during LOW of a write -> no wr_stb, all outputs at reset values; 300 short
//    writes -> abort_cnt saturates at 8'hFF.

Source files
------------

// File: rtl/ncgb_pkg.sv
// ncgb_pkg: write-sampler FSM states and MBC register address nibbles shared with the
// bank-register file that consumes the write strobes.
package ncgb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOW,
        ST_STUCK,
        ST_COMMIT
    } wr_state_t;

    localparam logic [3:0] ADDR_RAM_EN_0   = 4'h0;
    localparam logic [3:0] ADDR_RAM_EN_1   = 4'h1;
    localparam logic [3:0] ADDR_ROM_LO     = 4'h2;
    localparam logic [3:0] ADDR_ROM_HI     = 4'h3;
    localparam logic [3:0] ADDR_RAM_BANK_0 = 4'h4;
    localparam logic [3:0] ADDR_RAM_BANK_1 = 4'h5;
    localparam logic [3:0] ADDR_GAME_EN    = 4'hA;
    localparam logic [3:0] ADDR_GAME_SEL   = 4'hB;

endpackage

// File: rtl/ncgb_sync.sv
// ncgb_sync: DEPTH-flop synchronizer chain of width W; reset loads rst_val into every stage.
module ncgb_sync #(
    parameter int W     = 1,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] rst_val,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] sync_q [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) sync_q[i] <= rst_val;
        end else begin
            sync_q[0] <= d;
            for (int i = 1; i < DEPTH; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign q = sync_q[DEPTH-1];

endmodule

// File: rtl/gb_wr_sampler.sv
// gb_wr_sampler: turns asynchronous GB cartridge write cycles into single-cycle strobes.
// Optional NCGB_WR_DATA_VOTE_EN: latch data only when two consecutive synced samples agree.
module gb_wr_sampler
    import ncgb_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int MIN_LOW     = 2,
    parameter int MAX_LOW     = 64,
    parameter int CNT_W       = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       gb_wr_n,
    input  logic [3:0] gb_a,
    input  logic [7:0] gb_d,
    output logic       wr_stb,
    output logic [3:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy,
    output logic [7:0] abort_cnt
);

    logic       wr_s;
    logic [3:0] a_s;
    logic [7:0] d_s;

    ncgb_sync #(.W(1), .DEPTH(SYNC_STAGES)) u_sync_wr (
        .clk(clk), .rst(rst), .rst_val(1'b1), .d(gb_wr_n), .q(wr_s)
    );
    ncgb_sync #(.W(4), .DEPTH(SYNC_STAGES)) u_sync_a (
        .clk(clk), .rst(rst), .rst_val(4'h0), .d(gb_a), .q(a_s)
    );
    ncgb_sync #(.W(8), .DEPTH(SYNC_STAGES)) u_sync_d (
        .clk(clk), .rst(rst), .rst_val(8'h00), .d(gb_d), .q(d_s)
    );

    wr_state_t        state_q, state_d;
    logic [CNT_W-1:0] low_cnt_q, low_cnt_d, cnt_inc;
    logic [3:0]       lat_a_q, lat_a_d, wr_addr_q, wr_addr_d;
    logic [7:0]       lat_d_q, lat_d_d, wr_data_q, wr_data_d, abort_q, abort_d;
    logic             wr_stb_q, wr_stb_d, abort, d_ok;

`ifdef NCGB_WR_DATA_VOTE_EN
    logic [7:0] d_prev_q;
    always_ff @(posedge clk) d_prev_q <= rst ? 8'h00 : d_s;
    assign d_ok = (d_s == d_prev_q);
`else
    assign d_ok = 1'b1;
`endif

    assign cnt_inc = low_cnt_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        low_cnt_d = low_cnt_q;
        lat_a_d   = lat_a_q;
        lat_d_d   = lat_d_q;
        wr_stb_d  = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        abort     = 1'b0;
        case (state_q)
            ST_IDLE, ST_COMMIT: begin
                if (state_q == ST_COMMIT) begin
                    wr_stb_d  = 1'b1;
                    wr_addr_d = lat_a_q;
                    wr_data_d = lat_d_q;
                    state_d   = ST_IDLE;
                end
                // A new low cycle right behind a commit starts without a lost idle cycle
                if (!wr_s) begin
                    state_d   = ST_LOW;
                    low_cnt_d = CNT_W'(1);
                    lat_a_d   = a_s;
                    lat_d_d   = d_s;
                end
            end
            ST_LOW: begin
                if (wr_s) begin
                    state_d = (low_cnt_q >= CNT_W'(MIN_LOW)) ? ST_COMMIT : ST_IDLE;
                    abort   = (low_cnt_q < CNT_W'(MIN_LOW));
                end else begin
                    low_cnt_d = cnt_inc;
                    lat_d_d   = d_ok ? d_s : lat_d_q;
                    if (a_s != lat_a_q || cnt_inc >= CNT_W'(MAX_LOW)) begin
                        state_d = ST_STUCK;
                        abort   = 1'b1;
                    end
                end
            end
            default: state_d = wr_s ? ST_IDLE : ST_STUCK;
        endcase
        abort_d = (abort && abort_q != 8'hFF) ? abort_q + 1'b1 : abort_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            low_cnt_q <= '0;
            lat_a_q   <= '0;
            lat_d_q   <= '0;
            wr_stb_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            abort_q   <= '0;
        end else begin
            state_q   <= state_d;
            low_cnt_q <= low_cnt_d;
            lat_a_q   <= lat_a_d;
            lat_d_q   <= lat_d_d;
            wr_stb_q  <= wr_stb_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            abort_q   <= abort_d;
        end
    end

    assign wr_stb    = wr_stb_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign busy      = (state_q != ST_IDLE);
    assign abort_cnt = abort_q;

endmodule

// File: tb/tb_gb_wr_sampler.sv
// tb_gb_wr_sampler: directed vector table, reset/saturation sequences and randomized
// write transactions checked against a transaction-level model of the write protocol.
module tb_gb_wr_sampler;

    localparam int SS      = 2;
    localparam int MIN_LOW = 2;
    localparam int MAX_LOW = 64;
`ifdef NCGB_WR_DATA_VOTE_EN
    localparam bit VOTE = 1'b1;
`else
    localparam bit VOTE = 1'b0;
`endif

    logic       clk = 1'b0, rst = 1'b1, gb_wr_n = 1'b1;
    logic [3:0] gb_a = 4'h0;
    logic [7:0] gb_d = 8'h00;
    logic       wr_stb, busy;
    logic [3:0] wr_addr;
    logic [7:0] wr_data, abort_cnt;

    int checks = 0, failures = 0, edge_n = 0, exp_abort = 0;

    typedef struct {
        int         e;
        logic [3:0] a;
        logic [7:0] d;
    } stb_t;
    stb_t exp_q[$];

    typedef struct {
        int         len;
        logic [3:0] a;
        logic [3:0] a2;
        int         chg_at;
        logic [7:0] d;
        logic [7:0] d_last;
        logic       exp_stb;
        logic [7:0] exp_d;
    } vec_t;
    vec_t vt[9];

    logic [3:0] la_q[$];
    logic [7:0] ld_q[$];

    int         n, k, gap;
    logic [3:0] ra;
    logic       m_stb;
    logic [7:0] m_d;

    always #5 clk = ~clk;

    gb_wr_sampler dut (
        .clk(clk), .rst(rst), .gb_wr_n(gb_wr_n), .gb_a(gb_a), .gb_d(gb_d),
        .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .abort_cnt(abort_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", name, edge_n, act, exp);
        end
    endtask

    // One clock: drive raw bus, then check strobe against the expected-strobe queue
    task automatic step(input logic w, input logic [3:0] a, input logic [7:0] d);
        logic hit;
        gb_wr_n = w;
        gb_a    = a;
        gb_d    = d;
        @(posedge clk);
        edge_n++;
        @(negedge clk);
        hit = (exp_q.size() > 0) && (exp_q[0].e == edge_n);
        check("wr_stb", wr_stb, hit);
        if (hit) begin
            check("wr_addr", wr_addr, exp_q[0].a);
            check("wr_data", wr_data, exp_q[0].d);
            void'(exp_q.pop_front());
        end
    endtask

    // Drive gap idle cycles, the low samples in la_q/ld_q, then one high cycle
    task automatic burst(input int g, input logic es, input logic [7:0] ed);
        repeat (g) step(1'b1, la_q[0], ld_q[0]);
        if (es) exp_q.push_back('{edge_n + la_q.size() + 1 + SS + 1, la_q[0], ed});
        else exp_abort = (exp_abort < 255) ? exp_abort + 1 : 255;
        foreach (la_q[i]) step(1'b0, la_q[i], ld_q[i]);
        step(1'b1, la_q[la_q.size()-1], ld_q[ld_q.size()-1]);
    endtask

    // Write outcome from the protocol rules applied to the list of low-cycle samples
    function automatic void model(output logic stb, output logic [7:0] d);
        logic chg;
        chg = 1'b0;
        d   = ld_q[0];
        for (int i = 1; i < la_q.size(); i++) begin
            if (la_q[i] != la_q[0]) chg = 1'b1;
            if (!VOTE || ld_q[i] == ld_q[i-1]) d = ld_q[i];
        end
        stb = !chg && la_q.size() >= MIN_LOW && la_q.size() < MAX_LOW;
    endfunction

    task automatic idle_check(input string name);
        repeat (8) step(1'b1, gb_a, gb_d);
        check({name, "_abort"}, abort_cnt, exp_abort);
        check({name, "_busy"}, busy, 1'b0);
        check({name, "_queue"}, exp_q.size(), 0);
    endtask

    initial begin
        #10_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        vt[0] = '{10,  4'h2, 4'h2, 0, 8'h05, 8'h05, 1'b1, 8'h05};
        vt[1] = '{1,   4'h4, 4'h4, 0, 8'h13, 8'h13, 1'b0, 8'h00};
        vt[2] = '{100, 4'h7, 4'h7, 0, 8'h5A, 8'h5A, 1'b0, 8'h00};
        vt[3] = '{6,   4'h2, 4'h3, 3, 8'h11, 8'h11, 1'b0, 8'h00};
        vt[4] = '{5,   4'h3, 4'h3, 0, 8'h01, 8'h01, 1'b1, 8'h01};
        vt[5] = '{6,   4'h1, 4'h1, 0, 8'hAA, 8'h0A, 1'b1, VOTE ? 8'hAA : 8'h0A};
        vt[6] = '{2,   4'h5, 4'h5, 0, 8'h3C, 8'h3C, 1'b1, 8'h3C};
        vt[7] = '{63,  4'hB, 4'hB, 0, 8'hC3, 8'hC3, 1'b1, 8'hC3};
        vt[8] = '{64,  4'hA, 4'hA, 0, 8'h99, 8'h99, 1'b0, 8'h00};

        repeat (2) step(1'b1, 4'h0, 8'h00);
        check("rst_stb", wr_stb, 1'b0);
        check("rst_addr", wr_addr, 4'h0);
        check("rst_data", wr_data, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_abort", abort_cnt, 8'h00);
        rst = 1'b0;
        repeat (4) step(1'b1, 4'h0, 8'h00);

        foreach (vt[v]) begin
            la_q.delete();
            ld_q.delete();
            for (int i = 0; i < vt[v].len; i++) begin
                la_q.push_back((vt[v].chg_at != 0 && i >= vt[v].chg_at) ? vt[v].a2 : vt[v].a);
                ld_q.push_back((i == vt[v].len - 1) ? vt[v].d_last : vt[v].d);
            end
            burst(3, vt[v].exp_stb, vt[v].exp_d);
            idle_check($sformatf("vec%0d", v));
        end

        // Glitch filtering sequence: one-cycle FF glitch, then 0A settles
        la_q = '{4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2};
        ld_q = '{8'h0A, 8'h0A, 8'hFF, 8'h0A, 8'h0A, 8'h0A};
        model(m_stb, m_d);
        burst(2, m_stb, m_d);
        idle_check("glitch");

        // Reset in the middle of a low phase
        repeat (5) step(1'b0, 4'h1, 8'h77);
        check("mid_busy", busy, 1'b1);
        rst = 1'b1;
        step(1'b1, 4'h1, 8'h77);
        exp_abort = 0;
        check("mid_rst_addr", wr_addr, 4'h0);
        check("mid_rst_data", wr_data, 8'h00);
        check("mid_rst_abort", abort_cnt, 8'h00);
        check("mid_rst_busy", busy, 1'b0);
        rst = 1'b0;
        idle_check("mid_rst");

        for (int t = 0; t < 150; t++) begin
            n   = ($urandom_range(0, 9) == 0) ? $urandom_range(50, 80) : $urandom_range(1, 10);
            gap = $urandom_range(1, 4);
            ra  = 4'($urandom);
            k   = (n >= 2 && $urandom_range(0, 5) == 0) ? $urandom_range(1, n - 1) : 0;
            la_q.delete();
            ld_q.delete();
            for (int i = 0; i < n; i++) begin
                la_q.push_back((k != 0 && i >= k) ? ra ^ 4'($urandom_range(1, 15)) : ra);
                ld_q.push_back((i > 0 && $urandom_range(0, 1) == 1) ? ld_q[i-1] : 8'($urandom));
            end
            model(m_stb, m_d);
            burst(gap, m_stb, m_d);
        end
        idle_check("random");

        rst = 1'b1;
        step(1'b1, 4'h0, 8'h00);
        rst = 1'b0;
        exp_abort = 0;
        la_q = '{4'h4};
        ld_q = '{8'h13};
        repeat (254) burst(1, 1'b0, 8'h00);
        idle_check("sat254");
        repeat (46) burst(1, 1'b0, 8'h00);
        idle_check("sat300");
        check("sat_value", abort_cnt, 8'hFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
